// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the UART program loader.
// Latency: n/a (types only).
// Backpressure: n/a.
// Contents: loader frame-state enum, UART bit-state enum, frame header byte.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        LD_IDLE,
        LD_CNT_LO,
        LD_CNT_HI,
        LD_DATA,
        LD_CHECK,
        LD_DONE,
        LD_ERROR
    } ld_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    localparam logic [7:0] HDR_BYTE = 8'hA5;

endpackage

// File: rtl/imem_loader_if.sv
// Instruction-memory write port plus loader status, bundled for the loader top.
// Latency: n/a (wires only).
// Backpressure: none; the memory accepts a write on every imem_we strobe.
// Ports: imem_we/imem_waddr/imem_wdata (write port), core_hold, load_done,
//        load_error, words_loaded (status). master = loader, slave = consumer.
interface imem_loader_if;
    logic        imem_we;
    logic [31:0] imem_waddr;
    logic [31:0] imem_wdata;
    logic        core_hold;
    logic        load_done;
    logic        load_error;
    logic [15:0] words_loaded;

    modport master (
        output imem_we, imem_waddr, imem_wdata,
        output core_hold, load_done, load_error, words_loaded
    );

    modport slave (
        input imem_we, imem_waddr, imem_wdata,
        input core_hold, load_done, load_error, words_loaded
    );
endinterface

// File: rtl/imem_loader_uart_rx.sv
// 8N1 UART receiver with 2-FF input synchronizer and mid-bit sampling.
// Latency: rx_valid/rx_ferr pulse one cycle after the stop-bit centre sample.
// Backpressure: none; each received byte is presented for exactly one cycle.
// Ports: clk, reset (async, active-high), rx (serial in), rx_valid/rx_data
//        (good byte), rx_ferr (stop bit sampled low, byte discarded).
module uart_rx
    import imem_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       rx_ferr
);

    localparam int CW = $clog2(CLKS_PER_BIT);

    logic            rx_s1, rx_s2, rx_q;
    rx_state_t       st_q, st_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      sh_q, sh_d;
    logic            vld_d, ferr_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_q     <= 1'b1;
            st_q     <= RX_IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            sh_q     <= '0;
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
        end else begin
            rx_s1    <= rx;
            rx_s2    <= rx_s1;
            rx_q     <= rx_s2;
            st_q     <= st_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            sh_q     <= sh_d;
            rx_valid <= vld_d;
            rx_ferr  <= ferr_d;
        end
    end

    assign rx_data = sh_q;

    always_comb begin
        st_d   = st_q;
        cnt_d  = cnt_q;
        bit_d  = bit_q;
        sh_d   = sh_q;
        vld_d  = 1'b0;
        ferr_d = 1'b0;
        case (st_q)
            RX_IDLE: begin
                if (rx_q && !rx_s2) begin
                    st_d  = RX_START;
                    cnt_d = '0;
                end
            end
            RX_START: begin
                // A glitch shorter than half a bit falls back to idle.
                if (cnt_q == CW'(CLKS_PER_BIT / 2 - 1)) begin
                    cnt_d = '0;
                    bit_d = '0;
                    st_d  = rx_s2 ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
                    cnt_d = '0;
                    sh_d  = {rx_s2, sh_q[7:1]};
                    bit_d = bit_q + 1'b1;
                    if (bit_q == 3'd7) st_d = RX_STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
                    cnt_d  = '0;
                    st_d   = RX_IDLE;
                    vld_d  = rx_s2;
                    ferr_d = !rx_s2;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: st_d = RX_IDLE;
        endcase
    end

endmodule

// File: rtl/imem_loader.sv
// Frame parser that writes a UART-delivered program image into instruction memory.
// Latency: imem_we one cycle after the 4th byte of each word; status one cycle after the deciding byte.
// Backpressure: none; bytes arrive at line rate and every word is written immediately.
// Ports: clk, reset (async, active-high), rx (serial in), bus (imem_loader_if.master:
//        write port and core_hold/load_done/load_error/words_loaded status).
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int IMEM_DEPTH   = 256
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           rx,
    imem_loader_if.master  bus
);

    localparam int WIDX_W = $clog2(IMEM_DEPTH) + 1;

    logic       rx_valid, rx_ferr;
    logic [7:0] rx_data;

    uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk      (clk),
        .reset    (reset),
        .rx       (rx),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .rx_ferr  (rx_ferr)
    );

    ld_state_t         state_q, state_d;
    logic [15:0]       count_q;
    logic [23:0]       asm_q;
    logic [1:0]        byte_idx_q;
    logic [WIDX_W-1:0] word_idx_q;
    logic [7:0]        xor_q;
    logic              we_q, hold_q, done_q, err_q;
    logic [31:0]       waddr_q, wdata_q;
    logic [15:0]       words_q;
    logic              last_word;

    assign last_word = (byte_idx_q == 2'd3) &&
                       ((16'(word_idx_q) + 16'd1) == count_q);

    always_comb begin
        state_d = state_q;
        if (rx_ferr && (state_q inside {LD_CNT_LO, LD_CNT_HI, LD_DATA, LD_CHECK})) begin
            state_d = LD_ERROR;
        end else if (rx_valid) begin
            case (state_q)
                LD_IDLE, LD_DONE, LD_ERROR:
                    if (rx_data == HDR_BYTE) state_d = LD_CNT_LO;
                LD_CNT_LO: state_d = LD_CNT_HI;
                LD_CNT_HI: begin
                    if ({rx_data, count_q[7:0]} > 16'(IMEM_DEPTH)) state_d = LD_ERROR;
                    else if ({rx_data, count_q[7:0]} == 16'd0)    state_d = LD_CHECK;
                    else                                           state_d = LD_DATA;
                end
                LD_DATA:  if (last_word) state_d = LD_CHECK;
                LD_CHECK: state_d = (rx_data == xor_q) ? LD_DONE : LD_ERROR;
                default:  state_d = LD_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= LD_IDLE;
            count_q    <= '0;
            asm_q      <= '0;
            byte_idx_q <= '0;
            word_idx_q <= '0;
            xor_q      <= '0;
            we_q       <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            hold_q     <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            words_q    <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= 1'b0;

            // A new header restarts everything, whatever the previous outcome.
            if (state_d == LD_CNT_LO && state_q != LD_CNT_LO) begin
                done_q     <= 1'b0;
                err_q      <= 1'b0;
                words_q    <= '0;
                word_idx_q <= '0;
                byte_idx_q <= '0;
                xor_q      <= '0;
                hold_q     <= 1'b1;
            end

            if (rx_valid) begin
                case (state_q)
                    LD_CNT_LO: count_q[7:0]  <= rx_data;
                    LD_CNT_HI: count_q[15:8] <= rx_data;
                    LD_DATA: begin
                        xor_q      <= xor_q ^ rx_data;
                        byte_idx_q <= byte_idx_q + 1'b1;
                        case (byte_idx_q)
                            2'd0: asm_q[7:0]   <= rx_data;
                            2'd1: asm_q[15:8]  <= rx_data;
                            2'd2: asm_q[23:16] <= rx_data;
                            default: begin
                                // 4th byte goes straight to the write port.
                                we_q       <= 1'b1;
                                wdata_q    <= {rx_data, asm_q};
                                waddr_q    <= {{(32-WIDX_W-2){1'b0}}, word_idx_q, 2'b00};
                                word_idx_q <= word_idx_q + 1'b1;
                                words_q    <= words_q + 16'd1;
                            end
                        endcase
                    end
                    default: ;
                endcase
            end

            if (state_d == LD_DONE && state_q != LD_DONE) begin
                done_q <= 1'b1;
                hold_q <= 1'b0;
            end
            if (state_d == LD_ERROR && state_q != LD_ERROR) begin
                err_q  <= 1'b1;
                hold_q <= 1'b1;
            end
        end
    end

    assign bus.imem_we      = we_q;
    assign bus.imem_waddr   = waddr_q;
    assign bus.imem_wdata   = wdata_q;
    assign bus.core_hold    = hold_q;
    assign bus.load_done    = done_q;
    assign bus.load_error   = err_q;
    assign bus.words_loaded = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: frames are serialised onto rx, a frame-level
// model predicts the writes and final status, and a per-cycle monitor checks
// the write port and status invariants.
module tb_imem_loader;

    localparam int CPB = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic rx = 1'b1;

    always #5 clk = ~clk;

    imem_loader_if bus();

    imem_loader #(.CLKS_PER_BIT(CPB), .IMEM_DEPTH(256)) dut (
        .clk   (clk),
        .reset (reset),
        .rx    (rx),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_data_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Per-cycle monitor of the write port and status invariants.
    logic [31:0] last_addr, last_data;
    logic        prev_we;
    always @(negedge clk) begin
        if (reset) begin
            last_addr = '0;
            last_data = '0;
            prev_we   = 1'b0;
        end else begin
            if (bus.imem_we) begin
                check("we_single_cycle", {31'd0, prev_we}, 32'd0);
                if (exp_addr_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got addr %h data %h, required no write",
                             bus.imem_waddr, bus.imem_wdata);
                end else begin
                    check("waddr", bus.imem_waddr, exp_addr_q.pop_front());
                    check("wdata", bus.imem_wdata, exp_data_q.pop_front());
                end
                last_addr = bus.imem_waddr;
                last_data = bus.imem_wdata;
            end else begin
                check("waddr_hold", bus.imem_waddr, last_addr);
                check("wdata_hold", bus.imem_wdata, last_data);
            end
            check("hold_iff_not_done", {31'd0, bus.core_hold}, {31'd0, !bus.load_done});
            check("done_err_exclusive", {31'd0, bus.load_done & bus.load_error}, 32'd0);
            prev_we = bus.imem_we;
        end
    end

    function automatic logic [7:0] xor_data(input logic [7:0] b[$]);
        logic [7:0] x = 8'h00;
        int n = int'({b[2], b[1]});
        for (int i = 0; i < 4 * n; i++) x ^= b[3 + i];
        return x;
    endfunction

    // Frame-level model: queue the writes the frame must produce, and return
    // the final status it must leave behind.
    task automatic model_frame(input logic [7:0] b[$], output logic m_done,
                               output logic [15:0] m_words);
        int n = int'({b[2], b[1]});
        if (n > 256) begin
            m_done  = 1'b0;
            m_words = 16'd0;
            return;
        end
        for (int i = 0; i < n; i++) begin
            exp_addr_q.push_back(32'(i * 4));
            exp_data_q.push_back({b[3+4*i+3], b[3+4*i+2], b[3+4*i+1], b[3+4*i]});
        end
        m_words = 16'(n);
        m_done  = (b[3 + 4 * n] == xor_data(b));
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop_bit);
        @(posedge clk); #1 rx = 1'b0;
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(posedge clk);
            #1 rx = d[i];
        end
        repeat (CPB) @(posedge clk);
        #1 rx = stop_bit;
        repeat (CPB) @(posedge clk);
        #1 rx = 1'b1;
        repeat (CPB) @(posedge clk);
    endtask

    task automatic check_status(input string tag, input logic done, input logic err,
                                input logic [15:0] words);
        @(negedge clk);
        check({tag, "_load_done"},    {31'd0, bus.load_done},  {31'd0, done});
        check({tag, "_load_error"},   {31'd0, bus.load_error}, {31'd0, err});
        check({tag, "_core_hold"},    {31'd0, bus.core_hold},  {31'd0, !done});
        check({tag, "_words_loaded"}, {16'd0, bus.words_loaded}, {16'd0, words});
    endtask

    task automatic run_frame(input string tag, input logic [7:0] b[$]);
        logic        m_done;
        logic [15:0] m_words;
        model_frame(b, m_done, m_words);
        foreach (b[i]) send_byte(b[i], 1'b1);
        repeat (20) @(posedge clk);
        check_status(tag, m_done, !m_done, m_words);
        check({tag, "_writes_pending"}, 32'(exp_addr_q.size()), 32'd0);
    endtask

    task automatic check_reset_values(input string tag);
        @(negedge clk);
        check({tag, "_we"},    {31'd0, bus.imem_we}, 32'd0);
        check({tag, "_waddr"}, bus.imem_waddr, 32'd0);
        check({tag, "_wdata"}, bus.imem_wdata, 32'd0);
        check_status(tag, 1'b0, 1'b0, 16'd0);
    endtask

    logic [7:0] fr[$];

    initial begin
        // 1: reset values, then a long idle line.
        repeat (3) @(posedge clk);
        check_reset_values("reset");
        #1 reset = 1'b0;
        repeat (1000) @(posedge clk);
        check_status("idle", 1'b0, 1'b0, 16'd0);

        // 2: two-word program; data bytes XOR to 0xC1.
        fr = '{8'hA5, 8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00,
               8'h13, 8'h01, 8'h10, 8'h00, 8'hC1};
        check("pin_xor_two_words", {24'd0, xor_data(fr)}, 32'h0000_00C1);
        run_frame("two_words", fr);
        check("pin_two_words_count", {16'd0, bus.words_loaded}, 32'd2);
        check("pin_two_words_done", {31'd0, bus.load_done}, 32'd1);
        check("pin_two_words_addr", bus.imem_waddr, 32'h0000_0004);
        check("pin_two_words_data", bus.imem_wdata, 32'h0010_0113);

        // 3: same image, bad checksum: writes still happen, then error.
        fr[11] = 8'h01;
        run_frame("bad_csum", fr);
        check("pin_bad_csum_err", {31'd0, bus.load_error}, 32'd1);

        // 4: N=300 exceeds depth, then a valid single-word frame.
        fr = '{8'hA5, 8'h2C, 8'h01};
        run_frame("too_long", fr);
        fr = '{8'hA5, 8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h08};
        run_frame("one_word", fr);
        check("pin_one_word_data", bus.imem_wdata, 32'h1234_5678);

        // 5: empty image, then a bare header re-holds the core.
        fr = '{8'hA5, 8'h00, 8'h00, 8'h00};
        run_frame("empty", fr);
        send_byte(8'hA5, 1'b1);
        check_status("rehdr", 1'b0, 1'b0, 16'd0);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        repeat (20) @(posedge clk);
        check_status("rehdr_done", 1'b1, 1'b0, 16'd0);

        // 6a: framing error during DATA.
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h11, 1'b0);
        repeat (20) @(posedge clk);
        check_status("ferr", 1'b0, 1'b1, 16'd0);

        // 6b: reset mid-word, then the next image lands at address 0.
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'hAA, 1'b1);
        send_byte(8'hBB, 1'b1);
        #1 reset = 1'b1;
        check_reset_values("midreset");
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        fr = '{8'hA5, 8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h22};
        run_frame("after_reset", fr);
        check("pin_after_reset_addr", bus.imem_waddr, 32'h0000_0000);
        check("pin_after_reset_data", bus.imem_wdata, 32'hDEAD_BEEF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
